ysyx_22050243_lsu: RTL and testbench

Load/store unit between the execute stage and the data port of the `ysyx_22050243_Mem` memory block. It accepts one memory op at a time over a valid/ready handshake and aligns the address to a 64-bit word. It generates the bit-granular write mask and shifted write data, then drives a single-cycle memory request. For loads it captures, extracts and sign/zero-extends the returned word and holds the result for writeback until it is accepted.

---
 rtl/ysyx_22050243_pkg.sv | 12 +
 rtl/ysyx_22050243_lsu_if.sv | 31 +++
 rtl/ysyx_22050243_lsu_align.sv | 29 ++
 rtl/ysyx_22050243_lsu.sv | 78 +++++++
 tb/tb_ysyx_22050243_lsu.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050243_pkg.sv
// ysyx_22050243_pkg: access-size and LSU state encodings, data width, misalign rule.
package ysyx_22050243_pkg;
    localparam int XLEN = 64;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_e;
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        return size == SZ_H ? off[0] : size == SZ_W ? |off[1:0] : size == SZ_D ? |off : 1'b0;
    endfunction
endpackage

// File: rtl/ysyx_22050243_lsu_if.sv
// ysyx_22050243_lsu_if: execute op handshake, writeback result and memory data port of the LSU.
interface ysyx_22050243_lsu_if #(
    parameter int ADDR_W = 64
);
    import ysyx_22050243_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic              in_store;
    logic [1:0]        in_size;
    logic              in_unsigned;
    logic [ADDR_W-1:0] in_addr;
    logic [XLEN-1:0]   in_wdata;
    logic              data_r_en;
    logic              data_w_en;
    logic [ADDR_W-1:0] data_addr;
    logic [XLEN-1:0]   data_wmask;
    logic [XLEN-1:0]   data_w;
    logic [XLEN-1:0]   data_r;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_rdata;
    logic              out_misalign;
    modport slave (
        input  in_valid, in_store, in_size, in_unsigned, in_addr, in_wdata, data_r, out_ready,
        output in_ready, data_r_en, data_w_en, data_addr, data_wmask, data_w, out_valid, out_rdata, out_misalign
    );
    modport master (
        output in_valid, in_store, in_size, in_unsigned, in_addr, in_wdata, data_r, out_ready,
        input  in_ready, data_r_en, data_w_en, data_addr, data_wmask, data_w, out_valid, out_rdata, out_misalign
    );
endinterface

// File: rtl/ysyx_22050243_lsu_align.sv
// ysyx_22050243_lsu_align: byte-lane alignment; store mask/shift and load extract/extend.
module ysyx_22050243_lsu_align
    import ysyx_22050243_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [2:0]      off,
    input  logic            uns,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [XLEN-1:0] wmask,
    output logic [XLEN-1:0] wshift,
    output logic [XLEN-1:0] rdata
);
    logic [5:0]      sh;
    logic [7:0]      bmask;
    logic [XLEN-1:0] raw;
    assign sh = {off, 3'b000};
    // lanes past byte 7 fall off the 8-bit mask, which truncates unchecked misaligned stores
    assign bmask = (size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff) << off;
    for (genvar i = 0; i < 8; i++) begin : g_mask
        assign wmask[8*i +: 8] = {8{bmask[i]}};
    end
    assign wshift = wdata << sh;
    assign raw = rword >> sh;
    assign rdata = size == SZ_B ? {{56{~uns & raw[7]}}, raw[7:0]}
                 : size == SZ_H ? {{48{~uns & raw[15]}}, raw[15:0]}
                 : size == SZ_W ? {{32{~uns & raw[31]}}, raw[31:0]}
                 : raw;
endmodule

// File: rtl/ysyx_22050243_lsu.sv
// ysyx_22050243_lsu: one-op-at-a-time load/store FSM driving a single-cycle memory request.
// Define YSYX_22050243_LSU_MISALIGN_CHECK_EN to report misaligned ops instead of performing them.
module ysyx_22050243_lsu
    import ysyx_22050243_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = XLEN
) (
    input logic                clk,
    input logic                rst,
    ysyx_22050243_lsu_if.slave bus
);
    lsu_state_e        state, state_n;
    logic              store_q, uns_q, mis_q, mis_in, req, resp;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, wmask, wshift, ext;
`ifdef YSYX_22050243_LSU_MISALIGN_CHECK_EN
    assign mis_in = misaligned(bus.in_size, bus.in_addr[2:0]);
`else
    assign mis_in = 1'b0;
`endif
    ysyx_22050243_lsu_align u_align (
        .size   (size_q),
        .off    (addr_q[2:0]),
        .uns    (uns_q),
        .wdata  (wdata_q),
        .rword  (bus.data_r),
        .wmask  (wmask),
        .wshift (wshift),
        .rdata  (ext)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            store_q <= 1'b0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && bus.in_valid) begin
                store_q <= bus.in_store;
                uns_q   <= bus.in_unsigned;
                mis_q   <= mis_in;
                size_q  <= bus.in_size;
                addr_q  <= bus.in_addr;
                wdata_q <= bus.in_wdata;
                rdata_q <= '0;
            end
            if (state == S_WAIT) rdata_q <= ext;
        end
    end
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  state_n = bus.in_valid ? (mis_in ? S_RESP : S_REQ) : S_IDLE;
            S_REQ:   state_n = store_q ? S_RESP : S_WAIT;
            S_WAIT:  state_n = S_RESP;
            S_RESP:  state_n = bus.out_ready ? S_IDLE : S_RESP;
            default: state_n = S_IDLE;
        endcase
    end
    assign req              = state == S_REQ;
    assign resp             = state == S_RESP;
    assign bus.in_ready     = state == S_IDLE;
    assign bus.data_r_en    = req & ~store_q;
    assign bus.data_w_en    = req & store_q;
    assign bus.data_addr    = req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign bus.data_wmask   = req ? wmask : '0;
    assign bus.data_w       = req ? wshift : '0;
    assign bus.out_valid    = resp;
    assign bus.out_rdata    = resp ? rdata_q : '0;
    assign bus.out_misalign = resp & mis_q;
endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// tb_ysyx_22050243_lsu: vector table plus scoreboard queue for the LSU; honours YSYX_22050243_LSU_MISALIGN_CHECK_EN.
module tb_ysyx_22050243_lsu;
`ifdef YSYX_22050243_LSU_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    typedef struct {
        bit          store;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rword;
        logic [63:0] exp_rdata;
        logic [63:0] exp_mask;
        logic [63:0] exp_w;
        bit          exp_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rword;
    int          total = 0;
    int          bad = 0;
    vec_t        vecs[14];
    vec_t        sb[$];

    ysyx_22050243_lsu_if #(.ADDR_W(64)) bus ();
    ysyx_22050243_lsu dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // memory answers one cycle after a read strobe; otherwise it returns garbage
    always @(posedge clk) bus.data_r <= bus.data_r_en ? rword : 64'hA5A5_5A5A_DEAD_0BAD;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit st, logic [1:0] sz, bit u, logic [63:0] a, logic [63:0] wd,
                                logic [63:0] rw, logic [63:0] er, logic [63:0] em, logic [63:0] ew, bit mis);
        vec_t v;
        v.store = st; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.rword = rw;
        v.exp_rdata = er; v.exp_mask = em; v.exp_w = ew; v.exp_mis = mis;
        return v;
    endfunction

    task automatic do_op(input vec_t v, input int tag, input int hold);
        int          first_v, nr, nw, scyc, lat;
        logic [63:0] a_s, m_s, w_s;
        bit          busy_ok;
        vec_t        e;
        @(negedge clk);
        chk($sformatf("op%0d_in_ready_idle", tag), bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_store = v.store;
        bus.in_size = v.size;
        bus.in_unsigned = v.uns;
        bus.in_addr = v.addr;
        bus.in_wdata = v.wdata;
        bus.out_ready = hold == 0;
        rword = v.rword;
        sb.push_back(v);
        first_v = -1; nr = 0; nw = 0; scyc = -1; busy_ok = 1'b1;
        a_s = '0; m_s = '0; w_s = '0;
        for (int cyc = 1; cyc <= 10 && first_v < 0; cyc++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.data_r_en) begin nr++; scyc = cyc; a_s = bus.data_addr; end
            if (bus.data_w_en) begin
                nw++; scyc = cyc; a_s = bus.data_addr; m_s = bus.data_wmask; w_s = bus.data_w;
            end
            if (bus.in_ready) busy_ok = 1'b0;
            if (bus.out_valid) first_v = cyc;
        end
        e = sb.pop_front();
        lat = e.exp_mis ? 1 : e.store ? 2 : 3;
        chk($sformatf("op%0d_latency", tag), first_v, lat);
        chk($sformatf("op%0d_rd_strobes", tag), nr, (!e.store && !e.exp_mis) ? 1 : 0);
        chk($sformatf("op%0d_wr_strobes", tag), nw, (e.store && !e.exp_mis) ? 1 : 0);
        chk($sformatf("op%0d_strobe_cycle", tag), scyc, e.exp_mis ? -1 : 1);
        chk($sformatf("op%0d_data_addr", tag), a_s, e.exp_mis ? 64'h0 : e.addr & ~64'h7);
        chk($sformatf("op%0d_wmask", tag), m_s, (e.store && !e.exp_mis) ? e.exp_mask : 64'h0);
        chk($sformatf("op%0d_wdata", tag), w_s & e.exp_mask, (e.store && !e.exp_mis) ? e.exp_w : 64'h0);
        chk($sformatf("op%0d_busy_in_ready_low", tag), busy_ok, 1'b1);
        for (int k = 0; k < hold; k++) begin
            chk($sformatf("op%0d_hold%0d_rdata", tag, k), bus.out_rdata, e.exp_rdata);
            chk($sformatf("op%0d_hold%0d_valid", tag, k), bus.out_valid, 1'b1);
            chk($sformatf("op%0d_hold%0d_in_ready", tag, k), bus.in_ready, 1'b0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        chk($sformatf("op%0d_rdata", tag), bus.out_rdata, e.exp_rdata);
        chk($sformatf("op%0d_misalign", tag), bus.out_misalign, e.exp_mis);
        @(negedge clk);
        chk($sformatf("op%0d_back_idle", tag), bus.in_ready, 1'b1);
        chk($sformatf("op%0d_valid_dropped", tag), bus.out_valid, 1'b0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        rword = '0;
        bus.in_valid = 1'b0; bus.in_store = 1'b0; bus.in_size = 2'd0; bus.in_unsigned = 1'b0;
        bus.in_addr = '0; bus.in_wdata = '0; bus.out_ready = 1'b1;
        vecs[0]  = mk(0, 2'd0, 0, 64'h8000_0003, 0, 64'h1122_3344_8566_7788, 64'hFFFF_FFFF_FFFF_FF85, 0, 0, 0);
        vecs[1]  = mk(0, 2'd1, 1, 64'h8000_0006, 0, 64'h1122_3344_8566_7788, 64'h0000_0000_0000_1122, 0, 0, 0);
        vecs[2]  = mk(1, 2'd2, 0, 64'h8000_0004, 64'hDEAD_BEEF, 0, 0, 64'hFFFF_FFFF_0000_0000, 64'hDEAD_BEEF_0000_0000, 0);
        vecs[3]  = mk(0, 2'd3, 0, 64'h8000_0004, 0, 64'h1122_3344_8566_7788,
                      CHK ? 64'h0 : 64'h0000_0000_1122_3344, 0, 0, CHK);
        vecs[4]  = mk(0, 2'd2, 0, 64'h8000_0000, 0, 64'h1122_3344_8566_7788, 64'hFFFF_FFFF_8566_7788, 0, 0, 0);
        vecs[5]  = mk(0, 2'd2, 1, 64'h8000_0000, 0, 64'h1122_3344_8566_7788, 64'h0000_0000_8566_7788, 0, 0, 0);
        vecs[6]  = mk(0, 2'd1, 0, 64'h8000_0002, 0, 64'h1122_3344_8566_7788, 64'hFFFF_FFFF_FFFF_8566, 0, 0, 0);
        vecs[7]  = mk(0, 2'd0, 1, 64'h8000_0003, 0, 64'h1122_3344_8566_7788, 64'h0000_0000_0000_0085, 0, 0, 0);
        vecs[8]  = mk(0, 2'd3, 1, 64'h8000_0008, 0, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678, 0, 0, 0);
        vecs[9]  = mk(1, 2'd0, 0, 64'h8000_0007, 64'h1234_5678_9ABC_DE5A, 0, 0,
                      64'hFF00_0000_0000_0000, 64'h5A00_0000_0000_0000, 0);
        vecs[10] = mk(1, 2'd1, 0, 64'h0000_1002, 64'h0000_0000_0000_BEEF, 0, 0,
                      64'h0000_0000_FFFF_0000, 64'h0000_0000_BEEF_0000, 0);
        vecs[11] = mk(1, 2'd3, 0, 64'h0000_2000, 64'h0123_4567_89AB_CDEF, 0, 0,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 0);
        vecs[12] = mk(0, 2'd1, 0, 64'h8000_0001, 0, 64'h1122_3344_8566_7788,
                      CHK ? 64'h0 : 64'h0000_0000_0000_6677, 0, 0, CHK);
        vecs[13] = mk(1, 2'd2, 0, 64'h8000_0006, 64'h0000_0000_AABB_CCDD, 0, 0,
                      64'hFFFF_0000_0000_0000, 64'hCCDD_0000_0000_0000, CHK);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_r_en", bus.data_r_en, 1'b0);
        chk("rst_w_en", bus.data_w_en, 1'b0);
        chk("rst_data_addr", bus.data_addr, 64'h0);
        chk("rst_wmask", bus.data_wmask, 64'h0);
        chk("rst_data_w", bus.data_w, 64'h0);
        chk("rst_out_rdata", bus.out_rdata, 64'h0);
        chk("rst_misalign", bus.out_misalign, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) do_op(vecs[i], i, 0);
        do_op(vecs[0], 100, 5);
        do_op(vecs[2], 101, 0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_store = 1'b0; bus.in_size = 2'd0; bus.in_unsigned = 1'b0;
        bus.in_addr = 64'h8000_0003; rword = 64'h1122_3344_8566_7788; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rw_req_r_en", bus.data_r_en, 1'b1);
        @(negedge clk);
        chk("rw_wait_r_en", bus.data_r_en, 1'b0);
        chk("rw_wait_valid", bus.out_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_in_ready", bus.in_ready, 1'b1);
        chk("rw_out_valid", bus.out_valid, 1'b0);
        chk("rw_out_rdata", bus.out_rdata, 64'h0);
        chk("rw_data_addr", bus.data_addr, 64'h0);
        chk("rw_r_en", bus.data_r_en, 1'b0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rw_no_stale_resp", seen, 1'b0);
        do_op(vecs[4], 102, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
